// File: rtl/norm_pkg.sv
// Shared types and constants for the mantissa normaliser pipeline.
package norm_pkg;

  typedef enum logic {
    NORM_SINGLE = 1'b0,
    NORM_PACKED = 1'b1
  } norm_mode_e;

  localparam int NORM_WIDTH     = 53;
  localparam int NORM_SPLIT     = 24;
  localparam int NORM_TAG_W     = 4;
  // Low count bits left for the second-stage fine shift.
  localparam int NORM_FINE_BITS = 3;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/norm_lzc.sv
// Leading-zero counter for one lane; combinational, an all-zero lane
// returns the lane width and raises zero.
module norm_lzc
  import norm_pkg::*;
#(
  parameter int W = NORM_SPLIT
) (
  input  logic [W-1:0]        val,
  output logic [cnt_w(W)-1:0] cnt,
  output logic                zero
);

  localparam int CW = cnt_w(W);

  // Later iterations win, so the highest set bit sets the final count.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (val[i]) cnt = CW'(W - 1 - i);
    end
  end

  assign zero = (val == '0);

endmodule

// File: rtl/norm_pipe.sv
// Two-stage mantissa normaliser (single or two packed lanes), 2-cycle latency, valid/ready.
// NORM_PIPE_SKID_EN adds a 2-entry input skid buffer so o_ready comes straight from a flop.
module norm_pipe
  import norm_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH,
  parameter int SPLIT = NORM_SPLIT,
  parameter int TAG_W = NORM_TAG_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_mode,
  input  logic [WIDTH-1:0]        i_frac,
  input  logic [TAG_W-1:0]        i_tag,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIDTH-1:0]        o_res,
  output logic [cnt_w(WIDTH)-1:0] o_lz_hi,
  output logic [cnt_w(SPLIT)-1:0] o_lz_lo,
  output logic [1:0]              o_zero,
  output logic [TAG_W-1:0]        o_tag
);

  localparam int HW = WIDTH - SPLIT;
  localparam int CF = cnt_w(WIDTH);
  localparam int CH = cnt_w(HW);
  localparam int CL = cnt_w(SPLIT);
  localparam int FB = NORM_FINE_BITS;
  localparam int BW = 1 + WIDTH + TAG_W;

  logic          en1, en2, v1, v2;
  logic          src_vld, take;
  logic [BW-1:0] src_dat;

  assign en2 = ~v2 | i_ready;
  assign en1 = ~v1 | en2;

`ifdef NORM_PIPE_SKID_EN
  logic [BW-1:0] sk0, sk1, in_dat;
  logic [1:0]    sk_cnt;
  logic          rdy_q, in_fire, pop, push;

  // Invariant: rdy_q == (sk_cnt != 2). An empty buffer is bypassed.
  assign in_dat  = {i_mode, i_frac, i_tag};
  assign o_ready = rdy_q;
  assign in_fire = i_valid & rdy_q;
  assign src_vld = (sk_cnt != 2'd0) | i_valid;
  assign src_dat = (sk_cnt != 2'd0) ? sk0 : in_dat;
  assign pop     = (sk_cnt != 2'd0) & en1;
  assign push    = in_fire & ((sk_cnt != 2'd0) | ~en1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sk0    <= '0;
      sk1    <= '0;
      sk_cnt <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) sk0 <= in_dat;
          else                sk1 <= in_dat;
          sk_cnt <= sk_cnt + 2'd1;
          rdy_q  <= (sk_cnt == 2'd0);
        end
        2'b01: begin
          sk0    <= sk1;
          sk_cnt <= sk_cnt - 2'd1;
          rdy_q  <= 1'b1;
        end
        2'b11: sk0 <= in_dat;
        default: ;
      endcase
    end
  end
`else
  assign o_ready = en1;
  assign src_vld = i_valid;
  assign src_dat = {i_mode, i_frac, i_tag};
`endif

  assign take = src_vld & en1;

  logic             s_mode;
  logic [WIDTH-1:0] s_frac;
  logic [TAG_W-1:0] s_tag;
  assign {s_mode, s_frac, s_tag} = src_dat;

  logic [CH-1:0] lzh;
  logic [CL-1:0] lzl;
  logic          zh, zl;

  norm_lzc #(.W(HW)) u_lzc_hi (
    .val  (s_frac[WIDTH-1:SPLIT]),
    .cnt  (lzh),
    .zero (zh)
  );

  norm_lzc #(.W(SPLIT)) u_lzc_lo (
    .val  (s_frac[SPLIT-1:0]),
    .cnt  (lzl),
    .zero (zl)
  );

  logic [CF-1:0]    c_lz_hi;
  logic [CL-1:0]    c_lz_lo;
  logic [1:0]       c_zero;
  logic [WIDTH-1:0] c_frac;
  logic [CH-1:0]    sh_hi;
  logic [CL-1:0]    sh_lo;
  logic [CF-1:0]    sh_full;

  // Stage 1: coarse shift by the count with its low FB bits cleared.
  always_comb begin
    c_lz_hi = CF'(lzh);
    c_lz_lo = lzl;
    c_zero  = {zh, zl};
    c_frac  = '0;
    sh_hi   = (lzh >> FB) << FB;
    sh_lo   = (lzl >> FB) << FB;
    sh_full = '0;
    if (s_mode == NORM_PACKED) begin
      c_frac[WIDTH-1:SPLIT] = s_frac[WIDTH-1:SPLIT] << sh_hi;
      c_frac[SPLIT-1:0]     = s_frac[SPLIT-1:0] << sh_lo;
    end else begin
      // Full-width count reuses the lane counters: a zero high lane adds HW.
      c_lz_hi = zh ? (CF'(HW) + CF'(lzl)) : CF'(lzh);
      c_lz_lo = '0;
      c_zero  = {zh & zl, 1'b0};
      sh_full = (c_lz_hi >> FB) << FB;
      c_frac  = s_frac << sh_full;
    end
  end

  norm_mode_e       m1;
  logic [WIDTH-1:0] f1;
  logic [CF-1:0]    lzh1;
  logic [CL-1:0]    lzl1;
  logic [1:0]       z1;
  logic [TAG_W-1:0] t1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1   <= 1'b0;
      m1   <= NORM_SINGLE;
      f1   <= '0;
      lzh1 <= '0;
      lzl1 <= '0;
      z1   <= 2'b00;
      t1   <= '0;
    end else if (en1) begin
      v1 <= take;
      if (take) begin
        m1   <= norm_mode_e'(s_mode);
        f1   <= c_frac;
        lzh1 <= c_lz_hi;
        lzl1 <= c_lz_lo;
        z1   <= c_zero;
        t1   <= s_tag;
      end
    end
  end

  logic [WIDTH-1:0] r_res;

  always_comb begin
    r_res = '0;
    if (m1 == NORM_PACKED) begin
      r_res[WIDTH-1:SPLIT] = f1[WIDTH-1:SPLIT] << lzh1[FB-1:0];
      r_res[SPLIT-1:0]     = f1[SPLIT-1:0] << lzl1[FB-1:0];
    end else begin
      r_res = f1 << lzh1[FB-1:0];
    end
  end

  logic [WIDTH-1:0] res2;
  logic [CF-1:0]    lzh2;
  logic [CL-1:0]    lzl2;
  logic [1:0]       z2;
  logic [TAG_W-1:0] t2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v2   <= 1'b0;
      res2 <= '0;
      lzh2 <= '0;
      lzl2 <= '0;
      z2   <= 2'b00;
      t2   <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        res2 <= r_res;
        lzh2 <= lzh1;
        lzl2 <= lzl1;
        z2   <= z1;
        t2   <= t1;
      end
    end
  end

  assign o_valid = v2;
  assign o_res   = res2;
  assign o_lz_hi = lzh2;
  assign o_lz_lo = lzl2;
  assign o_zero  = z2;
  assign o_tag   = t2;

endmodule

// File: tb/tb_norm_pipe.sv
// Directed bench for norm_pipe: reset, per-vector latency/results, stall, random ready, reset in flight.
module tb_norm_pipe;

  localparam int WIDTH = 53;
  localparam int SPLIT = 24;
  localparam int TAG_W = 4;
`ifdef NORM_PIPE_SKID_EN
  localparam int STALL = 5;
`else
  localparam int STALL = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic             i_mode = 1'b0;
  logic [WIDTH-1:0] i_frac = '0;
  logic [TAG_W-1:0] i_tag = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] o_res;
  logic [5:0]       o_lz_hi;
  logic [4:0]       o_lz_lo;
  logic [1:0]       o_zero;
  logic [TAG_W-1:0] o_tag;

  always #5 clk = ~clk;

  norm_pipe #(.WIDTH(WIDTH), .SPLIT(SPLIT), .TAG_W(TAG_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .i_frac  (i_frac),
    .i_tag   (i_tag),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_lz_hi (o_lz_hi),
    .o_lz_lo (o_lz_lo),
    .o_zero  (o_zero),
    .o_tag   (o_tag)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic             t_mode [8];
  logic [WIDTH-1:0] t_frac [8];
  logic [WIDTH-1:0] t_res  [8];
  int               t_lzh  [8];
  int               t_lzl  [8];
  logic [1:0]       t_zero [8];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic set_vec(input int k, input logic m, input logic [WIDTH-1:0] f,
                         input logic [WIDTH-1:0] r, input int lh, input int ll,
                         input logic [1:0] z);
    t_mode[k] = m; t_frac[k] = f; t_res[k] = r;
    t_lzh[k] = lh; t_lzl[k] = ll; t_zero[k] = z;
  endtask

  task automatic drive(input int k);
    i_mode = t_mode[k];
    i_frac = t_frac[k];
    i_tag  = 4'(k);
  endtask

  task automatic check_out(input string nm, input int k);
    check({nm, "_res"},  o_res,   t_res[k]);
    check({nm, "_lzh"},  o_lz_hi, t_lzh[k]);
    check({nm, "_lzl"},  o_lz_lo, t_lzl[k]);
    check({nm, "_zero"}, o_zero,  t_zero[k]);
    check({nm, "_tag"},  o_tag,   k);
  endtask

  task automatic single(input int k);
    @(negedge clk);
    drive(k); i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    check($sformatf("lat1_vld%0d", k), o_valid, 1'b0);
    @(negedge clk);
    check($sformatf("lat2_vld%0d", k), o_valid, 1'b1);
    check_out($sformatf("single%0d", k), k);
  endtask

  task automatic stream(input int stall, input bit rnd, input string nm);
    int  in_i = 0;
    int  out_i = 0;
    int  cyc = 0;
    bit  fin, fout;
    while (out_i < 8 && cyc < 300) begin
      @(negedge clk);
      if (cyc < stall) i_ready = 1'b0;
      else             i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_i < 8) begin i_valid = 1'b1; drive(in_i); end
      else i_valid = 1'b0;
      #1;
      if (o_valid) check_out($sformatf("%s%0d", nm, out_i), out_i);
      if (!rnd && cyc == stall - 1) check({nm, "_full_rdy"}, o_ready, 1'b0);
`ifdef NORM_PIPE_SKID_EN
      if (!rnd && cyc == 2) check({nm, "_skid_rdy"}, o_ready, 1'b1);
`endif
      fin  = i_valid & o_ready;
      fout = o_valid & i_ready;
      @(posedge clk);
      if (fin)  in_i++;
      if (fout) out_i++;
      cyc++;
    end
    check({nm, "_count"}, out_i, 8);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    set_vec(0, 1'b0, 53'h1,                 53'h10_0000_0000_0000, 52, 0,  2'b00);
    set_vec(1, 1'b1, 53'h100_0010,          53'h10_0000_0080_0000, 28, 19, 2'b00);
    set_vec(2, 1'b0, 53'h0,                 53'h0,                 53, 0,  2'b10);
    set_vec(3, 1'b1, 53'h0,                 53'h0,                 29, 24, 2'b11);
    set_vec(4, 1'b0, 53'h20,                53'h10_0000_0000_0000, 47, 0,  2'b00);
    set_vec(5, 1'b1, 53'h1,                 53'h80_0000,           29, 23, 2'b10);
    set_vec(6, 1'b0, 53'h123_4567,          53'h12_3456_7000_0000, 28, 0,  2'b00);
    set_vec(7, 1'b1, 53'h10_0000_0000_0300, 53'h10_0000_00C0_0000, 0,  14, 2'b00);

    repeat (3) @(negedge clk);
    check("rst_vld",  o_valid, 1'b0);
    check("rst_res",  o_res,   0);
    check("rst_lzh",  o_lz_hi, 0);
    check("rst_lzl",  o_lz_lo, 0);
    check("rst_zero", o_zero,  0);
    check("rst_tag",  o_tag,   0);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", o_ready, 1'b1);

    for (int k = 0; k < 8; k++) single(k);
    @(negedge clk);
    i_ready = 1'b1;
    @(negedge clk);

    stream(STALL, 1'b0, "stall");
    stream(0, 1'b1, "rand");
    repeat (3) @(negedge clk);

    i_ready = 1'b0; i_valid = 1'b1; drive(0);
    @(negedge clk);
    drive(1);
    @(negedge clk);
    i_valid = 1'b0;
    check("flight_vld", o_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("flight_rst_vld", o_valid, 1'b0);
    check("flight_rst_tag", o_tag, 0);
    rst_n = 1'b1;
    #1;
    check("flight_rdy", o_ready, 1'b1);
    i_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | o_valid;
    end
    check("flight_flush", seen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/norm_pipe.md
NORM_PIPE -- requirements
Module: norm_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 53, giving the datapath width in bits.
REQ-002 The block SHALL have parameter SPLIT, default 24, giving the low-lane width in packed mode; the high lane is WIDTH-SPLIT bits.
REQ-003 The block SHALL have parameter TAG_W, default 4, giving the width of the sideband tag carried alongside each beat.
REQ-004 i_clk  input  1  the single clock; all logic is rising-edge.
REQ-005 i_rst_n  input  1  reset, synchronous and active-low.
REQ-006 i_valid  input  1  upstream beat present.
REQ-007 o_ready  output  1  block accepts a beat this cycle.
REQ-008 i_mode  input  1  0 = single lane of WIDTH bits; 1 = two packed lanes, [WIDTH-1:SPLIT] and [SPLIT-1:0].
REQ-009 i_frac  input  WIDTH  unnormalised mantissa(s).
REQ-010 i_tag  input  TAG_W  sideband, returned unchanged with the beat.
REQ-011 o_valid  output  1  result beat present.
REQ-012 i_ready  input  1  downstream accepts the beat.
REQ-013 o_res  output  WIDTH  normalised mantissa(s).
REQ-014 o_lz_hi  output  clog2(WIDTH+1)  leading-zero count of the high lane; in mode 0 it is the full-width count.
REQ-015 o_lz_lo  output  clog2(SPLIT+1)  leading-zero count of the low lane; 0 in mode 0.
REQ-016 o_zero  output  2  all-zero flags: bit1 = high lane or the single lane, bit0 = low lane (0 in mode 0).
REQ-017 o_tag  output  TAG_W  tag of the output beat.

Function
REQ-018 A beat SHALL transfer in when i_valid and o_ready are both 1, and transfer out when o_valid and i_ready are both 1.
REQ-019 In mode 0, o_res SHALL be i_frac shifted left by its leading-zero count, with zero fill.
REQ-020 In mode 1, each lane SHALL be shifted within its own bit field; no bits cross SPLIT.
REQ-021 An all-zero lane SHALL give a count equal to the lane width, a zero result and the zero flag set.
REQ-022 The pipeline SHALL have two register stages.
  - Stage 1: leading-zero count, then the coarse shift (upper count bits).
  - Stage 2: the fine shift (lower count bits).
  - Latency: 2 cycles from accept to o_valid when unstalled.
  - Throughput: 1 beat per cycle.
REQ-023 Stage enables SHALL be:
  - en2 = ~v2 | i_ready;
  - en1 = ~v1 | en2;
  - o_ready = en1 (combinational in the base build).
REQ-024 i_mode SHALL be captured with each beat, so consecutive beats may use different modes with no bubble.
REQ-025 While o_valid=1 and i_ready=0, all outputs SHALL hold stable and no beat is accepted once both stages are full.
REQ-026 A simultaneous accept and emit with both stages full SHALL advance the pipeline with no loss or duplication of beats.
REQ-027 Beats SHALL leave in acceptance order.

Reset
REQ-028 While i_rst_n=0 at a clock edge, all pipeline registers SHALL clear: o_valid=0, o_res=0, o_lz_hi=0, o_lz_lo=0, o_zero=0, o_tag=0.
REQ-029 A reset asserted while beats are in flight SHALL discard those beats.
REQ-030 o_ready SHALL be 1 in the first cycle after reset releases.

Configuration
REQ-031 Macro NORM_PIPE_SKID_EN SHALL select the input buffering.
  - Defined: a 2-entry skid buffer sits at the input, o_ready is driven directly from a flop, the buffer is bypassed when empty (latency stays 2), and o_ready deasserts only when the skid buffer holds 2 beats.
  - Undefined: no buffer, o_ready per REQ-023.
  - Both builds: identical beat ordering and results.

Structure
REQ-032 Package norm_pkg SHALL hold:
  - the mode enum (NORM_SINGLE=0, NORM_PACKED=1);
  - a count-width function clog2(n+1);
  - default parameter constants.
REQ-033 Sub-module norm_lzc SHALL implement a parametrised leading-zero counter with a zero flag, instantiated once per lane.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Mode 0, i_frac=53'h0_0000_0000_0001, i_ready=1 -> two cycles later o_res=53'h10_0000_0000_0000, o_lz_hi=52, o_zero=2'b00.
  - Mode 1, high lane 29'h0000_0001, low lane 24'h00_0010 -> o_res high=29'h1000_0000, low=24'h80_0000, o_lz_hi=28, o_lz_lo=19.
  - Mode 1, i_frac=0 -> o_lz_hi=29, o_lz_lo=24, o_zero=2'b11, o_res=0.
  - Back-to-back beats with alternating mode, i_ready held at 0 for 3 cycles -> output held stable, o_ready low once full, no loss and in-order tags 0..7.
  - Reset pulsed with 2 beats in flight -> o_valid=0 the next cycle, the beats are never emitted, o_ready=1.
  - With NORM_PIPE_SKID_EN, random i_ready at 50% -> results identical to the base build and o_ready glitch-free (flop-driven).
